blink_decoder: RTL and testbench

- Receive-side counterpart of the LED blinker: samples an asynchronous blink-coded input pin and measures mark (high) and space (low) run lengths.
- Classifies each mark as dot or dash and groups marks into characters separated by long spaces.
- Emits each character as a one-cycle VALID strobe with its code and length.
- Sits in the TinyFPGA BX top level beside the blinker, so either an external button/photodiode or a looped-back blinker LED can drive it.

---
 rtl/blink_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 23 ++
 rtl/blink_decoder.sv | 157 +++++++++++++++
 tb/tb_blink_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared types and timing helpers for the blink-code receiver.
// Thresholds are derived from the nominal dot length UNIT.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

    function automatic int dash_min(input int unit);
        return 2 * unit;
    endfunction

    function automatic int char_gap(input int unit);
        return 2 * unit;
    endfunction

    // Marks this short or shorter are treated as noise; never below one sample.
    function automatic int glitch_max(input int unit);
        int g;
        g = unit / 2 - 1;
        if (g < 1) begin
            g = 1;
        end
        return g;
    endfunction

    function automatic int len_w(input int max_syms);
        return $clog2(max_syms + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous pins, cleared by a
// synchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/blink_decoder.sv
// Blink-code receiver: measures mark/space run lengths on a synchronised pin,
// classifies dots and dashes and emits one strobe per completed character.
module blink_decoder
    import blink_pkg::*;
#(
    parameter int UNIT     = 4,
    parameter int MAX_SYMS = 8,
    parameter int CNT_W    = 8
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            PIN,
    output logic [MAX_SYMS-1:0]             CODE,
    output logic [len_w(MAX_SYMS)-1:0]      LEN,
    output logic                            VALID,
    output logic                            OVF,
    output logic                            BUSY,
    output logic                            LED
);

    localparam int LEN_W = len_w(MAX_SYMS);

    localparam logic [CNT_W-1:0]    CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    DASH_MIN   = CNT_W'(dash_min(UNIT));
    localparam logic [CNT_W-1:0]    GAP_LAST   = CNT_W'(char_gap(UNIT) - 1);
    localparam logic [CNT_W-1:0]    GLITCH_MAX = CNT_W'(glitch_max(UNIT));
    localparam logic [LEN_W-1:0]    N_ZERO     = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]    N_ONE      = LEN_W'(1);
    localparam logic [LEN_W-1:0]    N_MAX      = LEN_W'(MAX_SYMS);
    localparam logic [MAX_SYMS-1:0] BUF_ZERO   = {MAX_SYMS{1'b0}};

    logic                s_pin;
    state_t              state_r, state_n;
    logic [CNT_W-1:0]    cnt_r, cnt_n;
    logic [MAX_SYMS-1:0] buf_r, buf_n;
    logic [LEN_W-1:0]    nelem_r, nelem_n;
    logic                ovf_acc_r, ovf_n;
    logic                emit_s;
    logic                is_dash_s;

    sync_2ff u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (PIN),
        .q     (s_pin)
    );

    assign LED       = s_pin;
    assign is_dash_s = (cnt_r >= DASH_MIN);

    // Run-length state machine: next state, counter and element buffer.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        buf_n   = buf_r;
        nelem_n = nelem_r;
        ovf_n   = ovf_acc_r;
        emit_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (s_pin) begin
                    state_n = MARK;
                    cnt_n   = CNT_ONE;
                end else begin
                    state_n = IDLE;
                end
            end
            MARK: begin
                if (s_pin) begin
                    if (cnt_r != CNT_MAX) begin
                        cnt_n = cnt_r + CNT_ONE;
                    end else begin
                        cnt_n = cnt_r;
                    end
                end else if (cnt_r <= GLITCH_MAX) begin
                    // Noise pulse: drop it, but keep an open character alive.
                    if (nelem_r == N_ZERO) begin
                        state_n = IDLE;
                        cnt_n   = CNT_ZERO;
                    end else begin
                        state_n = SPACE;
                        cnt_n   = CNT_ONE;
                    end
                end else begin
                    if (nelem_r < N_MAX) begin
                        for (int i = 0; i < MAX_SYMS; i++) begin
                            if (nelem_r == LEN_W'(i)) begin
                                buf_n[i] = is_dash_s;
                            end else begin
                                buf_n[i] = buf_r[i];
                            end
                        end
                        nelem_n = nelem_r + N_ONE;
                    end else begin
                        ovf_n = 1'b1;
                    end
                    state_n = SPACE;
                    cnt_n   = CNT_ONE;
                end
            end
            SPACE: begin
                if (s_pin) begin
                    state_n = MARK;
                    cnt_n   = CNT_ONE;
                end else if (cnt_r >= GAP_LAST) begin
                    emit_s  = 1'b1;
                    state_n = IDLE;
                    cnt_n   = CNT_ZERO;
                    buf_n   = BUF_ZERO;
                    nelem_n = N_ZERO;
                    ovf_n   = 1'b0;
                end else begin
                    cnt_n = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = CNT_ZERO;
                buf_n   = BUF_ZERO;
                nelem_n = N_ZERO;
                ovf_n   = 1'b0;
            end
        endcase
    end

    // State, accumulator and registered character outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            buf_r     <= BUF_ZERO;
            nelem_r   <= N_ZERO;
            ovf_acc_r <= 1'b0;
            CODE      <= BUF_ZERO;
            LEN       <= N_ZERO;
            OVF       <= 1'b0;
            VALID     <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            buf_r     <= buf_n;
            nelem_r   <= nelem_n;
            ovf_acc_r <= ovf_n;
            VALID     <= emit_s;
            BUSY      <= (state_n != IDLE);
            if (emit_s) begin
                CODE <= buf_r;
                LEN  <= nelem_r;
                OVF  <= ovf_acc_r;
            end
        end
    end

endmodule

// File: tb/tb_blink_decoder.sv
// Randomised bench for blink_decoder: PIN is driven as alternating runs and a
// run-level model predicts each character strobe, its cycle and contents.
module tb_blink_decoder;

    localparam int UNIT     = 4;
    localparam int MAX_SYMS = 8;
    localparam int CNT_W    = 8;
    localparam int DASH     = 2 * UNIT;
    localparam int GAP      = 2 * UNIT;
    localparam int GLITCH   = (UNIT / 2 - 1 < 1) ? 1 : UNIT / 2 - 1;

    logic                CLK   = 1'b0;
    logic                RST_N = 1'b0;
    logic                PIN   = 1'b0;
    logic [MAX_SYMS-1:0] CODE;
    logic [3:0]          LEN;
    logic                VALID;
    logic                OVF;
    logic                BUSY;
    logic                LED;

    always #5 CLK = ~CLK;

    blink_decoder #(.UNIT(UNIT), .MAX_SYMS(MAX_SYMS), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .PIN   (PIN),
        .CODE  (CODE),
        .LEN   (LEN),
        .VALID (VALID),
        .OVF   (OVF),
        .BUSY  (BUSY),
        .LED   (LED)
    );

    typedef struct {
        int cyc;
        int code;
        int len;
        int ovf;
    } exp_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_rst = 0;
    bit   pin_at [0:65535];
    exp_t exp_q[$];

    // Model of the character being assembled, tracked per run.
    int   m_code = 0;
    int   m_len  = 0;
    int   m_ovf  = 0;
    bit   m_open = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!RST_N) begin
            last_rst <= cyc + 1;
        end
    end

    exp_t e;
    always @(negedge CLK) begin
        if (cyc >= 2 && cyc >= last_rst + 2) begin
            check("led_echo", int'(LED), int'(pin_at[cyc-1]));
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("missed_valid", cyc, e.cyc);
        end
        if (VALID) begin
            check("busy_in_valid", int'(BUSY), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("code", int'(CODE), e.code);
                check("len", int'(LEN), e.len);
                check("ovf", int'(OVF), e.ovf);
            end
        end
    end

    task automatic drive(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            PIN = v;
            pin_at[cyc+1] = v;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic mark(input int n);
        if (n > GLITCH) begin
            if (m_len < MAX_SYMS) begin
                if (n >= DASH) begin
                    m_code = m_code | (1 << m_len);
                end
                m_len++;
            end else begin
                m_ovf = 1;
            end
            m_open = 1'b1;
        end
        drive(1'b1, n);
        if (n >= 3) begin
            check("busy_mark", int'(BUSY), 1);
        end
    endtask

    task automatic space(input int m);
        exp_t x;
        if (m_open && m >= GAP) begin
            // First low sample at edge cyc+1; strobe follows the GAP-th synchronised low.
            x.cyc  = cyc + 1 + GAP + 1;
            x.code = m_code;
            x.len  = m_len;
            x.ovf  = m_ovf;
            exp_q.push_back(x);
            m_open = 1'b0;
            m_code = 0;
            m_len  = 0;
            m_ovf  = 0;
        end
        drive(1'b0, m);
        if (m >= GAP + 2) begin
            check("busy_idle", int'(BUSY), 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_code"}, int'(CODE), 0);
        check({tag, "_len"}, int'(LEN), 0);
        check({tag, "_ovf"}, int'(OVF), 0);
        check({tag, "_valid"}, int'(VALID), 0);
        check({tag, "_busy"}, int'(BUSY), 0);
        check({tag, "_led"}, int'(LED), 0);
    endtask

    initial begin
        RST_N = 1'b0;
        drive(1'b0, 4);
        check_all_zero("reset");
        RST_N = 1'b1;
        drive(1'b0, 3);

        // Letter A, then outputs must hold their values.
        mark(4); space(4); mark(12); space(12);
        check("hold_code_a", int'(CODE), 2);
        check("hold_len_a", int'(LEN), 2);
        check("hold_ovf_a", int'(OVF), 0);

        // Isolated glitch.
        mark(1); space(12);

        // Dash threshold.
        mark(7); space(12);
        mark(8); space(12);

        // Character gap threshold.
        mark(4); space(7); mark(4); space(12);
        mark(4); space(8); mark(4); space(12);

        // Overflow, then a fresh single dash.
        for (int i = 0; i < 9; i++) begin
            mark(4);
            if (i < 8) begin
                space(4);
            end else begin
                space(12);
            end
        end
        mark(8); space(12);

        // Reset in the middle of a character.
        mark(4); space(4); mark(4); space(2);
        RST_N = 1'b0;
        drive(1'b0, 1);
        RST_N  = 1'b1;
        m_open = 1'b0;
        m_code = 0;
        m_len  = 0;
        m_ovf  = 0;
        space(12);
        check_all_zero("after_reset");
        mark(4); space(12);

        // Random characters with boundary-heavy run lengths.
        for (int c = 0; c < 150; c++) begin
            int nm;
            nm = $urandom_range(1, 10);
            for (int k = 0; k < nm; k++) begin
                int ml;
                case ($urandom_range(0, 3))
                    0:       ml = $urandom_range(1, 2);
                    1:       ml = $urandom_range(DASH - 1, DASH);
                    default: ml = $urandom_range(1, 20);
                endcase
                mark(ml);
                if (k < nm - 1) begin
                    if ($urandom_range(0, 7) == 0) begin
                        space($urandom_range(1, GAP + 4));
                    end else begin
                        space($urandom_range(1, GAP - 1));
                    end
                end
            end
            space($urandom_range(GAP, GAP + 6));
        end

        drive(1'b0, 5);
        check("pending_valids", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
